// File: rtl/rom_seq.sv
// Plays LEN entries of an external synchronous ROM, holding each on dout for DUR cycles.
// The next entry is prefetched during playback so consecutive entries follow with no gap cycle.
module rom_seq #(
    parameter int unsigned AW  = 5,
    parameter int unsigned DW  = 4,
    parameter int unsigned LEN = 32,
    parameter int unsigned DUR = 3000000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    localparam int unsigned CW = (DUR > 1) ? $clog2(DUR) : 1;
    localparam logic [AW-1:0] LastIdx = AW'(LEN - 1);
    localparam logic [CW-1:0] LastCnt = CW'(DUR - 1);

    typedef enum logic [1:0] {StIdle, StPrime, StLoad, StPlay} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] nidx;

    // Successor index; wraps to 0 after LEN-1 so the wrap entry is always prefetched.
    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] i);
        return (i < LastIdx) ? i + AW'(1) : '0;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        nidx    = next_idx(idx_q);

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StPrime;
                    addr_d  = '0;
                end
            end
            StPrime: state_d = StLoad;
            StLoad: begin
                dout_d  = rom_data;
                valid_d = 1'b1;
                idx_d   = '0;
                cnt_d   = '0;
                addr_d  = next_idx('0);
                state_d = StPlay;
            end
            StPlay: begin
                if (cnt_q == LastCnt) begin
                    if (idx_q == LastIdx && !loop) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                        dout_d  = '0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        dout_d = rom_data;
                        idx_d  = nidx;
                        cnt_d  = '0;
                        addr_d = next_idx(nidx);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over entry expiry and completion on the same edge.
        if (stop && state_q != StIdle) begin
            state_d = StIdle;
            valid_d = 1'b0;
            dout_d  = '0;
            done_d  = 1'b0;
            idx_d   = '0;
            cnt_d   = '0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rom_addr = addr_q;
    assign dout     = dout_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
